// File: rtl/d_latch.sv
// d_latch: level-sensitive, WIDTH-bit transparent latch with an asynchronous,
// active-low reset. The clk input is the latch gate: Q follows D_IN while clk
// sits at the enable level and holds the last value once clk leaves it.
module d_latch #(
    parameter int              WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter bit              ENABLE_HIGH = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] D_IN,
    output logic [WIDTH-1:0] Q
);

    // Gate level in positive sense, so the storage element below is written
    // once and serves both transparency polarities.
    logic             open_d;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    // Decode the transparency level; a non-inverted copy of clk when high-enabled.
    always_comb begin
        open_d = ENABLE_HIGH ? clk : ~clk;
    end

    // Value the latch loads when it is open: the raw input, no filtering.
    always_comb begin
        q_d = D_IN;
    end

    // Storage: reset dominates asynchronously, otherwise load while open and
    // hold while closed. All bits share one gate, so they latch together.
    always_latch begin
        if (!rst) begin
            q_q <= RESET_VALUE;
        end else if (open_d) begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

endmodule

// File: tb/tb_d_latch.sv
// tb_d_latch: drives three latch configurations (1-bit high-enable, 8-bit
// high-enable with a non-zero reset value, 1-bit low-enable) from a shared
// gate/reset pair and checks them against a history-based reference model.
module tb_d_latch;

    logic       clk;
    logic       rst;
    logic [0:0] d1;
    logic [7:0] d8;
    logic [0:0] d0;
    logic [0:0] q1;
    logic [7:0] q8;
    logic [0:0] q0;

    int compared   = 0;
    int mismatched = 0;

    // Every applied input combination, oldest first.
    bit       hist_rst[$];
    bit       hist_clk[$];
    bit [0:0] hist_d1[$];
    bit [7:0] hist_d8[$];
    bit [0:0] hist_d0[$];

    d_latch #(.WIDTH(1), .RESET_VALUE(1'b0), .ENABLE_HIGH(1'b1)) u_w1 (
        .clk(clk), .rst(rst), .D_IN(d1), .Q(q1)
    );

    d_latch #(.WIDTH(8), .RESET_VALUE(8'hA5), .ENABLE_HIGH(1'b1)) u_w8 (
        .clk(clk), .rst(rst), .D_IN(d8), .Q(q8)
    );

    d_latch #(.WIDTH(1), .RESET_VALUE(1'b0), .ENABLE_HIGH(1'b0)) u_low (
        .clk(clk), .rst(rst), .D_IN(d0), .Q(q0)
    );

    // Reference: walk back through the input history to the latest step that
    // determined the output -- a reset step gives the reset value, an open
    // step gives the data present then; closed steps are skipped.
    function automatic logic [7:0] model(input bit eh, input logic [7:0] rv, input int sel);
        for (int i = hist_rst.size() - 1; i >= 0; i--) begin
            if (!hist_rst[i]) return rv;
            if (hist_clk[i] == eh) begin
                if (sel == 8) return hist_d8[i];
                if (sel == 0) return {7'b0, hist_d0[i]};
                return {7'b0, hist_d1[i]};
            end
        end
        return 8'hxx;
    endfunction

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one input combination, let it settle for 1 time unit, then check
    // all three instances against the model.
    task automatic step(input bit r, input bit c, input bit [0:0] a, input bit [7:0] b,
                        input bit [0:0] e, input string tag);
        rst = r;
        clk = c;
        d1  = a;
        d8  = b;
        d0  = e;
        hist_rst.push_back(r);
        hist_clk.push_back(c);
        hist_d1.push_back(a);
        hist_d8.push_back(b);
        hist_d0.push_back(e);
        #1;
        $display("[%0t] %s rst=%b clk=%b d1=%b d8=%h d0=%b -> q1=%b q8=%h q0=%b",
                 $time, tag, r, c, a, b, e, q1, q8, q0);
        cmp({tag, ".q1"}, {7'b0, q1}, model(1'b1, 8'h00, 1));
        cmp({tag, ".q8"}, q8,         model(1'b1, 8'hA5, 8));
        cmp({tag, ".q0"}, {7'b0, q0}, model(1'b0, 8'h00, 0));
        #4;
    endtask

    initial begin
        bit       r;
        bit       c;
        bit [0:0] a;
        bit [0:0] e;
        bit [7:0] b;
        int       pick;

        // Reset while transparent: output forced regardless of D_IN.
        step(1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, "rst_open");
        cmp("rst_open.q1_const", {7'b0, q1}, 8'h00);
        cmp("rst_open.q8_const", q8, 8'hA5);
        step(1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, "rst_d_change");
        cmp("rst_d_change.q1_const", {7'b0, q1}, 8'h00);

        // Release while open: immediate pass-through, then follow D_IN.
        step(1'b1, 1'b1, 1'b1, 8'h3C, 1'b0, "release_open");
        cmp("release_open.q1_const", {7'b0, q1}, 8'h01);
        cmp("release_open.q8_const", q8, 8'h3C);
        step(1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, "follow0");
        cmp("follow0.q1_const", {7'b0, q1}, 8'h00);
        step(1'b1, 1'b1, 1'b1, 8'h3C, 1'b0, "follow1");
        cmp("follow1.q1_const", {7'b0, q1}, 8'h01);

        // Close the gate, wiggle the data: outputs hold.
        step(1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, "close");
        step(1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, "hold_t0");
        step(1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, "hold_t1");
        step(1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, "hold_t2");
        cmp("hold.q1_const", {7'b0, q1}, 8'h01);
        cmp("hold.q8_const", q8, 8'h3C);
        step(1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, "reopen");
        cmp("reopen.q1_const", {7'b0, q1}, 8'h00);
        cmp("reopen.q8_const", q8, 8'hFF);

        // Reset while closed acts without clk; release while closed keeps reset value.
        step(1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, "load1");
        step(1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, "close1");
        step(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, "rst_closed");
        cmp("rst_closed.q1_const", {7'b0, q1}, 8'h00);
        step(1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, "release_closed");
        cmp("release_closed.q1_const", {7'b0, q1}, 8'h00);
        cmp("release_closed.q8_const", q8, 8'hA5);
        step(1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, "open_after");
        cmp("open_after.q1_const", {7'b0, q1}, 8'h01);

        // Low-enable instance: transparent at clk=0, holds at clk=1.
        step(1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, "low_open");
        cmp("low_open.q0_const", {7'b0, q0}, 8'h01);
        step(1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, "low_close");
        step(1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, "low_hold");
        cmp("low_hold.q0_const", {7'b0, q0}, 8'h01);

        // Random walk: one input changes per step so no change coincides
        // with a gate edge.
        r = 1'b1; c = 1'b1; a = 1'b1; b = 8'hFF; e = 1'b0;
        for (int n = 0; n < 300; n++) begin
            pick = $urandom_range(0, 9);
            if (pick == 0)      r = ~r;
            else if (pick < 4)  c = ~c;
            else if (pick < 6)  a = 1'($urandom);
            else if (pick < 8)  b = 8'($urandom);
            else                e = 1'($urandom);
            step(r, c, a, b, e, $sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/d_latch.md
Name: d_latch

Overview:
- Level-sensitive D latch with an asynchronous, active-low reset.
- Used as a storage element wherever a transparent-while-enabled hold is wanted, e.g. clock-gating enable capture or time-borrowing paths.
- The single clock acts as the latch enable:
  - clk high: transparent (Q follows D_IN).
  - clk low: opaque (Q holds).
- The data path is parameterised in width; the default is a 1-bit latch.

Parameters:
- WIDTH, 1, bit width of D_IN and Q (legal range 1..64).
- RESET_VALUE, 0 (WIDTH bits), value forced onto Q while reset is asserted.
- ENABLE_HIGH, 1, transparency polarity. 1 = transparent while clk=1; 0 = transparent while clk=0.

Ports:
- clk  input  1  latch enable. Transparency level is set by ENABLE_HIGH.
- rst  input  1  asynchronous reset, active-low (asserted when rst=0).
- D_IN  input  WIDTH  data input.
- Q  output  WIDTH  latched data output.

Behaviour:
- Reset dominates:
  - While rst=0, Q=RESET_VALUE, regardless of clk or D_IN.
  - Assertion takes effect immediately (asynchronous); no clock edge is needed.
- Transparent phase (rst=1, clk at enable level):
  - Q follows D_IN combinationally, with zero cycles of latency.
  - Every D_IN change propagates to Q within the same delta/time step.
- Opaque phase (rst=1, clk at non-enable level):
  - Q holds the value D_IN had at the instant clk left the enable level.
  - D_IN changes while opaque have no effect on Q.
- Reset release (rst 0->1):
  - If clk is at the enable level, Q immediately takes D_IN.
  - Otherwise Q keeps RESET_VALUE until the next transparent phase.
- Reset mid-transparency: Q goes to RESET_VALUE at once, then resumes following D_IN on release.
- Simultaneous D_IN change and clk closing edge: Q captures the D_IN value present at the closing instant. D_IN must be stable around the closing edge; the setup/hold window is a timing constraint, not a functional rule.
- All WIDTH bits latch together. There are no per-bit enables.
- Implementation:
  - Latch inference, or a library latch cell per bit.
  - No flip-flops and no glitch filtering.
  - Synthesis must report a latch, not a combinational loop.
- X handling: X or Z on rst or clk must not be masked. Simulation shall propagate X to Q.
- Power-up: Q is undefined until the first reset assertion or the first transparent phase.

Test Plan:
- WIDTH=1, ENABLE_HIGH=1. rst=0, clk=1, D_IN=1 -> Q=0 immediately. Then D_IN=0 -> Q stays 0.
- Release rst=1 with clk=1, D_IN=1 -> Q=1 at once. D_IN=0 at t+7 -> Q=0. D_IN=1 at t+14 -> Q=1 (transparent following).
- rst=1, clk=1, D_IN=1; clk->0; then D_IN toggles 0,1,0 -> Q holds 1 throughout. clk->1 -> Q=0.
- rst=1, clk=0, Q holding 1. Assert rst=0 -> Q=0 without any clk activity. Release with clk=0 -> Q stays 0 until clk=1.
- WIDTH=8, RESET_VALUE=8'hA5:
  - During reset -> Q=8'hA5.
  - Transparent with D_IN=8'h3C -> Q=8'h3C.
  - Close the latch, D_IN=8'hFF -> Q=8'h3C.
- ENABLE_HIGH=0. clk=0, D_IN=1 -> Q=1. clk=1, D_IN=0 -> Q=1 (holds).
